// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state codes and default sizes for the FIFO pop arbiter slice
package fifo_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        ERROR  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first eligible index at or after rr_ptr
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    // scan offsets downward so the nearest eligible index after rr_ptr is the last one kept
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eligible[rr_ptr + IDX_W'(k)]) begin
                found  = 1'b1;
                winner = rr_ptr + IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/fifo_pop_arbiter.sv
// fifo_pop_arbiter: round-robin pop controller sharing one downstream path among input FIFOs
module fifo_pop_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IDX_W      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_REQ-1:0]            fifo_empty,
    input  logic [NUM_REQ-1:0]            fifo_error,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] fifo_data,
    input  logic                          pausa_in,
    output logic [NUM_REQ-1:0]            fifo_pop,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          valid_out,
    output logic [IDX_W-1:0]              dest_out,
    output logic [1:0]                    state_out,
    output logic                          error_out
);

    state_t             state, state_next;
    logic [NUM_REQ-1:0] mask1, mask2, eligible;
    logic [IDX_W-1:0]   rr_ptr, winner, sel_q;
    logic               found, pop_ok, pend, any_err, to_error;

    assign any_err   = |fifo_error;
    assign to_error  = (state_next == ERROR);
    assign state_out = state;
    assign error_out = (state == ERROR);

    // FIFO flags lag a pop by one cycle, so a just-popped FIFO stays masked for two cycles
    assign eligible = ~fifo_empty & ~mask1 & ~mask2;

    rr_pick #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_pick (
        .eligible(eligible),
        .rr_ptr  (rr_ptr),
        .found   (found),
        .winner  (winner)
    );

    assign pop_ok   = (state == RUN) && enable && !pausa_in && found;
    assign fifo_pop = pop_ok ? (NUM_REQ'(1) << winner) : '0;

    // next state: error dominates, ERROR only leaves through reset
    always_comb begin
        state_next = state;
        if (state == IDLE || state == RUN)
            state_next = any_err ? ERROR : !enable ? IDLE : pausa_in ? PAUSED : RUN;
        else if (state == PAUSED)
            state_next = any_err ? ERROR : (!pausa_in && enable) ? RUN : !enable ? IDLE : PAUSED;
    end

    // state, pointer and stale-flag masks
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            mask1  <= '0;
            mask2  <= '0;
        end else begin
            state  <= state_next;
            rr_ptr <= pop_ok ? winner + IDX_W'(1) : rr_ptr;
            mask1  <= fifo_pop;
            mask2  <= mask1;
        end
    end

    // read data arrives the cycle after a pop; capture it then, dropping anything caught by ERROR
    always_ff @(posedge clk) begin
        if (reset) begin
            pend      <= 1'b0;
            sel_q     <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            dest_out  <= '0;
        end else begin
            pend      <= pop_ok && !to_error;
            sel_q     <= pop_ok ? winner : sel_q;
            valid_out <= pend && !to_error;
            if (pend && !to_error) begin
                data_out <= fifo_data[sel_q*DATA_WIDTH +: DATA_WIDTH];
                dest_out <= sel_q;
            end
        end
    end

endmodule
